// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a scaled framebuffer window and incremental linear address.
// Define VGA_TIMING_FRAME_CNT_EN to add the 8-bit frame_count output.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_POL      = 1'b0,
  parameter bit V_POL      = 1'b0,
  parameter int WIN_X0     = 0,
  parameter int WIN_Y0     = 0,
  parameter int WIN_W      = 160,
  parameter int WIN_H      = 120,
  parameter int SCALE_LOG2 = 2,
  parameter int CW         = 10,
  parameter int AW         = 15
) (
  input  logic          clk_25,
  input  logic          reset,
  output logic          h_sync,
  output logic          v_sync,
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic          bright,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic [AW-1:0] pix_addr,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [7:0]    frame_count
`endif
);

  localparam logic [31:0] H_TOTAL      = 32'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [31:0] V_TOTAL      = 32'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [31:0] H_SYNC_START = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] H_SYNC_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] V_SYNC_START = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] V_SYNC_END   = 32'(V_ACTIVE + V_FP + V_SYNC);
  // Window bounds are exclusive on the upper side, in raster pixels.
  localparam logic [31:0] WIN_X1       = 32'(WIN_X0 + (WIN_W << SCALE_LOG2));
  localparam logic [31:0] WIN_Y1       = 32'(WIN_Y0 + (WIN_H << SCALE_LOG2));
  localparam logic [31:0] SUB_MASK     = 32'((1 << SCALE_LOG2) - 1);

  logic [CW-1:0] hc_q, hc_d;
  logic [CW-1:0] vc_q, vc_d;
  logic [AW-1:0] rowBase_q, rowBase_d;
  logic [31:0]   hcWide, vcWide, xOff, yOff;
  logic          hWrap, vWrap, inWinX, inWinY, bright_d;
  logic [CW-1:0] pixX_d, pixY_d;
  logic [AW-1:0] pixAddr_d;

  always_comb begin
    hcWide = 32'(hc_q);
    vcWide = 32'(vc_q);
    hWrap  = (hcWide == H_TOTAL - 32'd1);
    vWrap  = (vcWide == V_TOTAL - 32'd1);

    hc_d = hWrap ? '0 : hc_q + CW'(1);
    vc_d = vc_q;
    if (hWrap) vc_d = vWrap ? '0 : vc_q + CW'(1);

    xOff     = hcWide - 32'(WIN_X0);
    yOff     = vcWide - 32'(WIN_Y0);
    inWinX   = (hcWide >= 32'(WIN_X0)) && (hcWide < WIN_X1);
    inWinY   = (vcWide >= 32'(WIN_Y0)) && (vcWide < WIN_Y1);
    bright_d = inWinX && inWinY && (hcWide < 32'(H_ACTIVE)) && (vcWide < 32'(V_ACTIVE));

    pixX_d    = '0;
    pixY_d    = '0;
    pixAddr_d = '0;
    if (bright_d) begin
      pixX_d    = CW'(xOff >> SCALE_LOG2);
      pixY_d    = CW'(yOff >> SCALE_LOG2);
      pixAddr_d = rowBase_q + AW'(pixX_d);
    end

    // Row base advances once the last raster line of a source row finishes.
    rowBase_d = rowBase_q;
    if (hWrap) begin
      if (vWrap)
        rowBase_d = '0;
      else if (inWinY && ((yOff & SUB_MASK) == SUB_MASK))
        rowBase_d = rowBase_q + AW'(WIN_W);
    end
  end

  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      hc_q        <= '0;
      vc_q        <= '0;
      rowBase_q   <= '0;
      h_count     <= '0;
      v_count     <= '0;
      h_sync      <= ~H_POL;
      v_sync      <= ~V_POL;
      bright      <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_addr    <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      rowBase_q   <= rowBase_d;
      h_count     <= hc_q;
      v_count     <= vc_q;
      h_sync      <= (hcWide >= H_SYNC_START && hcWide < H_SYNC_END) ? H_POL : ~H_POL;
      v_sync      <= (vcWide >= V_SYNC_START && vcWide < V_SYNC_END) ? V_POL : ~V_POL;
      bright      <= bright_d;
      pix_x       <= pixX_d;
      pix_y       <= pixY_d;
      pix_addr    <= pixAddr_d;
      line_start  <= (hc_q == '0);
      frame_start <= (hc_q == '0) && (vc_q == '0);
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // The frame start reported right after reset release is not counted.
  logic firstFrame_q;

  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      frame_count  <= '0;
      firstFrame_q <= 1'b1;
    end else begin
      firstFrame_q <= 1'b0;
      if ((hc_q == '0) && (vc_q == '0) && !firstFrame_q)
        frame_count <= frame_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, small scaled and small offset/clipped instances compared
// each cycle with an arithmetic raster model, plus directed spot checks and random async resets.
module tb_vga_timing_gen;

  typedef struct {
    int hA, hF, hS, hB, vA, vF, vS, vB;
    bit hPol, vPol;
    int x0, y0, w, h, s;
  } cfg_t;

  typedef struct {
    logic hs, vs, br, ls, fs;
    int   hc, vc, px, py, addr, fc;
  } exp_t;

  logic   clk25 = 1'b0;
  logic   rst;
  int     checkCount = 0;
  int     errorCount = 0;
  longint tick = -1;
  cfg_t   cfgDef, cfgSmall, cfgOff;

  always #5 clk25 = ~clk25;

  logic dHs, dVs, dBr, dLs, dFs, sHs, sVs, sBr, sLs, sFs, oHs, oVs, oBr, oLs, oFs;
  logic [9:0]  dHc, dVc, dPx, dPy, sHc, sVc, sPx, sPy, oHc, oVc, oPx, oPy;
  logic [14:0] dAddr, sAddr, oAddr;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0]  dFc, sFc, oFc;
`endif

  vga_timing_gen dutDef (
    .clk_25(clk25), .reset(rst), .h_sync(dHs), .v_sync(dVs), .h_count(dHc), .v_count(dVc),
    .bright(dBr), .pix_x(dPx), .pix_y(dPy), .pix_addr(dAddr), .line_start(dLs), .frame_start(dFs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_count(dFc)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .H_POL(1'b1), .V_POL(1'b0), .WIN_X0(2), .WIN_Y0(1), .WIN_W(6), .WIN_H(5), .SCALE_LOG2(1)
  ) dutSmall (
    .clk_25(clk25), .reset(rst), .h_sync(sHs), .v_sync(sVs), .h_count(sHc), .v_count(sVc),
    .bright(sBr), .pix_x(sPx), .pix_y(sPy), .pix_addr(sAddr), .line_start(sLs), .frame_start(sFs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_count(sFc)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .H_POL(1'b0), .V_POL(1'b1), .WIN_X0(12), .WIN_Y0(9), .WIN_W(6), .WIN_H(4), .SCALE_LOG2(0)
  ) dutOff (
    .clk_25(clk25), .reset(rst), .h_sync(oHs), .v_sync(oVs), .h_count(oHc), .v_count(oVc),
    .bright(oBr), .pix_x(oPx), .pix_y(oPy), .pix_addr(oAddr), .line_start(oLs), .frame_start(oFs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_count(oFc)
`endif
  );

  // Expected outputs t cycles after reset release (t < 0 means reset is asserted).
  function automatic exp_t model(input cfg_t c, input longint t);
    exp_t e;
    int   hT, vT, hc, vc;
    bit   inWin;
    hT = c.hA + c.hF + c.hS + c.hB;
    vT = c.vA + c.vF + c.vS + c.vB;
    e.hs = ~c.hPol; e.vs = ~c.vPol; e.br = 1'b0; e.ls = 1'b0; e.fs = 1'b0;
    e.hc = 0; e.vc = 0; e.px = 0; e.py = 0; e.addr = 0; e.fc = 0;
    if (t < 0) return e;
    hc = int'(t % longint'(hT));
    vc = int'((t / longint'(hT)) % longint'(vT));
    e.hc = hc;
    e.vc = vc;
    e.hs = (hc >= c.hA + c.hF && hc < c.hA + c.hF + c.hS) ? c.hPol : ~c.hPol;
    e.vs = (vc >= c.vA + c.vF && vc < c.vA + c.vF + c.vS) ? c.vPol : ~c.vPol;
    inWin = hc >= c.x0 && hc < c.x0 + c.w * (1 << c.s) &&
            vc >= c.y0 && vc < c.y0 + c.h * (1 << c.s);
    e.br = inWin && hc < c.hA && vc < c.vA;
    if (e.br) begin
      e.px   = (hc - c.x0) / (1 << c.s);
      e.py   = (vc - c.y0) / (1 << c.s);
      e.addr = e.py * c.w + e.px;
    end
    e.ls = (hc == 0);
    e.fs = (hc == 0) && (vc == 0);
    e.fc = int'((t / longint'(hT * vT)) % 256);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkDut(input string who, input cfg_t c, input logic hs, input logic vs,
                          input logic [9:0] hc, input logic [9:0] vc, input logic br,
                          input logic [9:0] px, input logic [9:0] py, input logic [14:0] addr,
                          input logic ls, input logic fs);
    exp_t e;
    e = model(c, tick);
    checkOutput({who, ".h_sync"}, 32'(hs), 32'(e.hs));
    checkOutput({who, ".v_sync"}, 32'(vs), 32'(e.vs));
    checkOutput({who, ".h_count"}, 32'(hc), 32'(e.hc));
    checkOutput({who, ".v_count"}, 32'(vc), 32'(e.vc));
    checkOutput({who, ".bright"}, 32'(br), 32'(e.br));
    checkOutput({who, ".pix_x"}, 32'(px), 32'(e.px));
    checkOutput({who, ".pix_y"}, 32'(py), 32'(e.py));
    checkOutput({who, ".pix_addr"}, 32'(addr), 32'(e.addr));
    checkOutput({who, ".line_start"}, 32'(ls), 32'(e.ls));
    checkOutput({who, ".frame_start"}, 32'(fs), 32'(e.fs));
  endtask

  task automatic checkAll();
    checkDut("def", cfgDef, dHs, dVs, dHc, dVc, dBr, dPx, dPy, dAddr, dLs, dFs);
    checkDut("small", cfgSmall, sHs, sVs, sHc, sVc, sBr, sPx, sPy, sAddr, sLs, sFs);
    checkDut("off", cfgOff, oHs, oVs, oHc, oVc, oBr, oPx, oPy, oAddr, oLs, oFs);
`ifdef VGA_TIMING_FRAME_CNT_EN
    checkOutput("def.frame_count", 32'(dFc), 32'(model(cfgDef, tick).fc));
    checkOutput("small.frame_count", 32'(sFc), 32'(model(cfgSmall, tick).fc));
    checkOutput("off.frame_count", 32'(oFc), 32'(model(cfgOff, tick).fc));
`endif
  endtask

  // Advance n clocks, sampling and checking every instance on each falling edge.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk25);
      if (!rst) tick++;
      @(negedge clk25);
      checkAll();
    end
  endtask

  initial begin
    int     lowCount, vLow, brCount, maxAddr, waited;
    longint lastLs, lastFs;
    bit     lsDone, fsDone;

    cfgDef   = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 0, 0, 160, 120, 2};
    cfgSmall = '{16, 2, 3, 3, 12, 2, 2, 3, 1'b1, 1'b0, 2, 1, 6, 5, 1};
    cfgOff   = '{16, 2, 3, 3, 12, 2, 2, 3, 1'b0, 1'b1, 12, 9, 6, 4, 0};

    rst = 1'b1;
    repeat (5) @(posedge clk25);
    @(negedge clk25);
    checkAll();
    rst = 1'b0;
    applyStimulus(1);
    $display("[TB] reset released, checking first raster position");
    checkOutput("rel.h_count", 32'(dHc), 32'd0);
    checkOutput("rel.v_count", 32'(dVc), 32'd0);
    checkOutput("rel.frame_start", 32'(dFs), 32'd1);
    checkOutput("rel.h_sync", 32'(dHs), 32'd1);
    checkOutput("rel.v_sync", 32'(dVs), 32'd1);
    checkOutput("rel.bright", 32'(dBr), 32'd1);
    checkOutput("rel.pix_addr", 32'(dAddr), 32'd0);

    applyStimulus(4);
    checkOutput("def@4,0.pix_x", 32'(dPx), 32'd1);
    checkOutput("def@4,0.pix_addr", 32'(dAddr), 32'd1);

    lowCount = 0; vLow = 0; brCount = 0; maxAddr = 0;
    lastLs = 0; lastFs = 0; lsDone = 0; fsDone = 0;
    while (tick < 3200) begin
      applyStimulus(1);
      if (tick >= 5 && tick < 805 && !dHs) lowCount++;
      if (tick < 456) begin
        if (!sVs) vLow++;
        if (oBr) brCount++;
        if (int'(sAddr) > maxAddr) maxAddr = int'(sAddr);
      end
      if (dLs) begin
        if (!lsDone) begin
          checkOutput("def.line_start_period", 32'(tick - lastLs), 32'd800);
          lsDone = 1;
        end
        lastLs = tick;
      end
      if (sFs) begin
        if (!fsDone) begin
          checkOutput("small.frame_start_period", 32'(tick - lastFs), 32'd456);
          fsDone = 1;
        end
        lastFs = tick;
      end
      if (tick == 640) begin
        checkOutput("def@640,0.bright", 32'(dBr), 32'd0);
        checkOutput("def@640,0.pix_addr", 32'(dAddr), 32'd0);
      end
      if (tick == 799) checkOutput("def@799.h_count", 32'(dHc), 32'd799);
      if (tick == 800) begin
        checkOutput("def@800.h_count", 32'(dHc), 32'd0);
        checkOutput("def@800.v_count", 32'(dVc), 32'd1);
      end
      if (tick == 228) begin
        checkOutput("off.first_pixel.bright", 32'(oBr), 32'd1);
        checkOutput("off.first_pixel.pix_addr", 32'(oAddr), 32'd0);
      end
      if (tick == 455) checkOutput("small.last_line", 32'(sVc), 32'd18);
      if (tick == 456) checkOutput("small.v_wrap", 32'(sVc), 32'd0);
    end
    checkOutput("def.h_sync_low_cycles", 32'(lowCount), 32'd96);
    checkOutput("small.v_sync_low_cycles", 32'(vLow), 32'd48);
    checkOutput("off.bright_cycles_per_frame", 32'(brCount), 32'd12);
    checkOutput("small.max_pix_addr", 32'(maxAddr), 32'd29);
    checkOutput("def@0,4.pix_y", 32'(dPy), 32'd1);
    checkOutput("def@0,4.pix_addr", 32'(dAddr), 32'd160);

    waited = 0;
    while (dHc != 10'd300 && waited < 1000) begin
      applyStimulus(1);
      waited++;
    end
    checkOutput("def.reach_h300", 32'(dHc), 32'd300);
    $display("[TB] asserting reset mid-line");
    #2;
    rst  = 1'b1;
    tick = -1;
    #1;
    checkAll();
    checkOutput("midreset.h_count", 32'(dHc), 32'd0);
    checkOutput("midreset.h_sync", 32'(dHs), 32'd1);
    @(negedge clk25);
    checkAll();
    rst = 1'b0;
    applyStimulus(1);
    checkOutput("restart.h_count", 32'(dHc), 32'd0);
    checkOutput("restart.v_count", 32'(dVc), 32'd0);
    checkOutput("restart.frame_start", 32'(dFs), 32'd1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    checkOutput("restart.frame_count", 32'(sFc), 32'd0);
    applyStimulus(456);
    checkOutput("small.frame_count_after_frame", 32'(sFc), 32'd1);
`endif

    for (int k = 0; k < 6; k++) begin
      applyStimulus(int'($urandom_range(30, 1500)));
      #($urandom_range(1, 3));
      rst  = 1'b1;
      tick = -1;
      #1;
      checkAll();
      applyStimulus(int'($urandom_range(1, 3)));
      rst = 1'b0;
    end
    applyStimulus(600);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
